// File: rtl/skew_feed_ctrl_if.sv
// skew_feed_ctrl_if: sequencer/FIFO/PE-grid signals of the skewed west-edge feeder
interface skew_feed_ctrl_if #(
    parameter int ROWS  = 4,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [ROWS-1:0]  fifo_empty;
    logic [ROWS-1:0]  fifo_rd_en;
    logic [ROWS-1:0]  row_valid;
    logic             shift_en;
    logic             busy;
    logic             done;

    modport master (
        output start, len, fifo_empty,
        input  fifo_rd_en, row_valid, shift_en, busy, done
    );

    modport slave (
        input  start, len, fifo_empty,
        output fifo_rd_en, row_valid, shift_en, busy, done
    );
endinterface

// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: lockstep diagonally skewed reads from ROWS FIFOs into the systolic array west edge
module skew_feed_ctrl #(
    parameter int ROWS      = 4,
    parameter int LEN_W     = 8,
    parameter int DRAIN_CYC = 4
) (
    input logic             clk,
    input logic             rst,
    skew_feed_ctrl_if.slave bus
);
    localparam int SW = LEN_W + $clog2(ROWS) + 1;
    localparam int DW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FEED  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    step_q, step_d, last_step;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [ROWS-1:0]  need, rd_en, row_valid_q, row_valid_d;
    logic             shift_en_q, shift_en_d, advance;

    // row i is live while the shared step sits inside its skewed window [i, i+len_q)
    always_comb begin
        need = '0;
        for (int i = 0; i < ROWS; i++)
            need[i] = state_q == FEED && step_q >= SW'(i) && (step_q - SW'(i)) < SW'(len_q);
        advance   = state_q == FEED && (need & bus.fifo_empty) == '0;
        rd_en     = need & {ROWS{advance}};
        last_step = SW'(len_q) + SW'(ROWS) - SW'(2);
    end

    // pass sequencing: feed until the last skewed step, flush the grid, pulse done
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        len_d       = len_q;
        drain_d     = drain_q;
        row_valid_d = rd_en;
        shift_en_d  = advance || state_q == DRAIN;
        case (state_q)
            IDLE: if (bus.start) begin
                len_d   = bus.len;
                step_d  = '0;
                state_d = bus.len == '0 ? DONE : FEED;
            end
            FEED: if (advance) begin
                step_d  = step_q + SW'(1);
                drain_d = '0;
                state_d = step_q == last_step ? (DRAIN_CYC == 0 ? DONE : DRAIN) : FEED;
            end
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                state_d = drain_q == DW'(DRAIN_CYC - 1) ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; reset aborts any pass without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            len_q       <= '0;
            drain_q     <= '0;
            row_valid_q <= '0;
            shift_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            len_q       <= len_d;
            drain_q     <= drain_d;
            row_valid_q <= row_valid_d;
            shift_en_q  <= shift_en_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.row_valid  = row_valid_q;
    assign bus.shift_en   = shift_en_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DONE;
endmodule
